// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between riscv_pipeline, mem_port_arbiter and the unified memory.
// master = arbiter view; slave = pipeline/memory view.
interface mem_port_arbiter_if;
    logic [31:0] inst_adr;
    logic [31:0] inst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        mem_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_adr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    // Handshake: m_req/m_we/m_adr/m_wdata stay stable from request until the
    // cycle m_ready=1; that cycle completes the access and m_rdata is valid.
    modport master (
        input  inst_adr, mem_read, mem_write, data_adr, data_out, m_rdata, m_ready,
        output inst, data_in, mem_stall, m_req, m_we, m_adr, m_wdata
    );

    modport slave (
        output inst_adr, mem_read, mem_write, data_adr, data_out, m_rdata, m_ready,
        input  inst, data_in, mem_stall, m_req, m_we, m_adr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between pipeline data and fetch ports: data access, then fetch, then one released step.
// Define ARB_PERF_CNT_EN to build the stall / access performance counters.
module mem_port_arbiter #(
    parameter int unsigned WAIT_MAX = 255,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus,
    output logic               bus_err,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_acc_cnt,
    output logic [1:0]         dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        FETCH   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] WAIT_LIM = 16'(WAIT_MAX);

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] data_q, data_d;
    logic        bus_err_q, bus_err_d;
    logic        in_acc;
    logic        hit;

    assign in_acc = (state_q == DATA) || (state_q == FETCH);
    // A response arriving on the hit cycle still wins over the abort.
    assign hit    = (wait_q == WAIT_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            inst_q    <= NOP_INST;
            data_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            inst_q    <= inst_d;
            data_q    <= data_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        inst_d    = inst_q;
        data_d    = data_q;
        bus_err_d = bus_err_q;
        case (state_q)
            IDLE: begin
                wait_d  = '0;
                state_d = (bus.mem_write || bus.mem_read) ? DATA : FETCH;
            end
            DATA: begin
                if (bus.m_ready) begin
                    if (bus.mem_read && !bus.mem_write) data_d = bus.m_rdata;
                    wait_d  = '0;
                    state_d = FETCH;
                end else if (hit) begin
                    data_d    = '0;
                    bus_err_d = 1'b1;
                    wait_d    = '0;
                    state_d   = FETCH;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            FETCH: begin
                if (bus.m_ready) begin
                    inst_d  = bus.m_rdata;
                    state_d = RELEASE;
                end else if (hit) begin
                    inst_d    = NOP_INST;
                    bus_err_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs decode from state so an async reset drops m_req at once.
    always_comb begin
        bus.m_req   = in_acc;
        bus.m_we    = 1'b0;
        bus.m_adr   = '0;
        bus.m_wdata = '0;
        if (state_q == DATA) begin
            bus.m_we    = bus.mem_write;
            bus.m_adr   = bus.data_adr;
            bus.m_wdata = bus.data_out;
        end else if (state_q == FETCH) begin
            bus.m_adr = bus.inst_adr;
        end
    end

    assign bus.mem_stall = (state_q != RELEASE);
    assign bus.inst      = inst_q;
    assign bus.data_in   = data_q;
    assign bus_err       = bus_err_q;
    assign dbg_state_o   = state_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, acc_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            acc_cnt_q   <= '0;
        end else begin
            if (bus.mem_stall)         stall_cnt_q <= stall_cnt_q + 32'd1;
            if (in_acc && bus.m_ready) acc_cnt_q   <= acc_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_acc_cnt   = acc_cnt_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_acc_cnt   = 32'h0;
`endif
endmodule
